// File: rtl/rns2bin_32_31_21_5.sv
// rns2bin_32_31_21_5
// Reverse (RNS -> binary) converter for the moduli set {32, 31, 21, 5},
// dynamic range 104160. Uses Mixed-Radix Conversion with one digit per
// cycle:
//   X = a1 + 32*a2 + 992*a3 + 20832*a4
// a1 is r1 itself and is folded directly into the partial sum P. The later
// digits are added to P as they are produced, so the individual digits never
// need their own registers.
//
// Ports
//   clk, reset       rising-edge clock, asynchronous active-low reset
//   in_mod_1..4      residues mod 32, 31, 21, 5 (in_mod_4 uses bits [2:0])
//   in_valid/ready   input handshake; ready only when idle
//   out_N            converted value (0 when the tuple was illegal)
//   out_err          accepted tuple held an out-of-range residue
//   out_valid/ready  output handshake; outputs hold while stalled
module rns2bin_32_31_21_5 #(
  parameter int DYN_SIZE   = 16,
  parameter int MOD_SIZE_1 = 5,
  parameter int MOD_SIZE_2 = 5,
  parameter int MOD_SIZE_3 = 5,
  parameter int MOD_SIZE_4 = 3,
  parameter int MAX_MOD    = MOD_SIZE_1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_MOD-1:0] in_mod_1,
  input  logic [MAX_MOD-1:0] in_mod_2,
  input  logic [MAX_MOD-1:0] in_mod_3,
  input  logic [MAX_MOD-1:0] in_mod_4,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DYN_SIZE:0]  out_N,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [2:0] {IDLE, S_A2, S_A3, S_A4, DONE} state_t;

  state_t                  state_q, state_d;
  logic [MOD_SIZE_2-1:0]   r2_q, r2_d;
  logic [MOD_SIZE_3-1:0]   r3_q, r3_d;
  logic [MOD_SIZE_4-1:0]   r4_q, r4_d;
  logic [14:0]             p_q, p_d;      // partial sum, always < 20832
  logic                    err_q, err_d;
  logic [DYN_SIZE:0]       out_n_q, out_n_d;
  logic                    out_err_q, out_err_d;
  logic                    out_valid_q, out_valid_d;

  // Only the low bits of the mod-5 port carry a residue.
  logic [MAX_MOD-MOD_SIZE_4-1:0] unused_mod4_hi;
  assign unused_mod4_hi = in_mod_4[MAX_MOD-1:MOD_SIZE_4];

  // Reductions of the partial sum, combinational within the state cycle.
  logic [4:0] pm31, pm21;
  logic [2:0] pm5;
  assign pm31 = 5'(p_q % 15'd31);
  assign pm21 = 5'(p_q % 15'd21);
  assign pm5  = 3'(p_q % 15'd5);

  // Modular differences are formed as (r + m - p) so nothing goes negative.
  // Widths leave headroom for illegal residues (e.g. r2 = 31, r3 up to 31,
  // r4 up to 7); the result is garbage then, but out_N is forced to 0.
  logic [5:0] d2, d3;
  logic [3:0] d4;
  logic [4:0] a2, t3, a3;
  logic [2:0] t4, a4;
  logic [DYN_SIZE:0] sum;

  assign d2  = {1'b0, r2_q} + 6'd31 - {1'b0, pm31};
  assign a2  = 5'(d2 % 6'd31);                        // inv(32) mod 31 = 1
  assign d3  = {1'b0, r3_q} + 6'd21 - {1'b0, pm21};
  assign t3  = 5'(d3 % 6'd21);
  assign a3  = 5'(({5'd0, t3} * 10'd17) % 10'd21);    // inv(992) mod 21 = 17
  assign d4  = {1'b0, r4_q} + 4'd5 - {1'b0, pm5};
  assign t4  = 3'(d4 % 4'd5);
  assign a4  = 3'(({1'b0, t4} * 4'd3) % 4'd5);        // inv(20832) mod 5 = 3
  assign sum = 17'(p_q) + 17'(a4) * 17'd20832;

  always_comb begin
    state_d     = state_q;
    r2_d        = r2_q;
    r3_d        = r3_q;
    r4_d        = r4_q;
    p_d         = p_q;
    err_d       = err_q;
    out_n_d     = out_n_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r2_d    = in_mod_2[MOD_SIZE_2-1:0];
          r3_d    = in_mod_3[MOD_SIZE_3-1:0];
          r4_d    = in_mod_4[MOD_SIZE_4-1:0];
          p_d     = 15'(in_mod_1);                     // a1 = r1
          // The r1 term is always false at 5 bits; kept for width-generic form.
          err_d   = (6'(in_mod_1) >= 6'd32) |
                    (in_mod_2 >= 5'd31) |
                    (in_mod_3 >= 5'd21) |
                    (in_mod_4[MOD_SIZE_4-1:0] >= 3'd5);
          state_d = S_A2;
        end
      end
      S_A2: begin
        p_d     = p_q + {5'd0, a2, 5'd0};              // + 32*a2
        state_d = S_A3;
      end
      S_A3: begin
        p_d     = p_q + 15'(a3) * 15'd992;
        state_d = S_A4;
      end
      S_A4: begin
        out_n_d     = err_q ? '0 : sum;
        out_err_d   = err_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      r2_q        <= '0;
      r3_q        <= '0;
      r4_q        <= '0;
      p_q         <= '0;
      err_q       <= 1'b0;
      out_n_q     <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      r2_q        <= r2_d;
      r3_q        <= r3_d;
      r4_q        <= r4_d;
      p_q         <= p_d;
      err_q       <= err_d;
      out_n_q     <= out_n_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_N     = out_n_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rns2bin_32_31_21_5.sv
// Scoreboard bench for rns2bin_32_31_21_5. The expected value comes from a
// CRT search over the dynamic range; a negedge monitor checks latency and
// pops/compares results on each output handshake.
module tb_rns2bin_32_31_21_5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [4:0]  in_mod_1 = '0, in_mod_2 = '0, in_mod_3 = '0, in_mod_4 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] out_N;
  logic        out_err;
  logic        out_valid;
  logic        out_ready = 1'b1;

  rns2bin_32_31_21_5 dut (
    .clk(clk), .reset(reset),
    .in_mod_1(in_mod_1), .in_mod_2(in_mod_2), .in_mod_3(in_mod_3), .in_mod_4(in_mod_4),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_N(out_N), .out_err(out_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int n; int e; } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   total = 0, bad = 0;
  int   rdy_mode = 0;   // 0: ready high, 1: ready low, 2: random
  logic vld_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'b0;
    else                    out_ready = ($urandom % 4) != 0;
  end

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // CRT by search: the unique x < 104160 matching every residue.
  function automatic exp_t model(input int r1, input int r2, input int r3, input int r4);
    exp_t r;
    int   m4;
    m4  = r4 % 8;
    r.e = (r1 >= 32 || r2 >= 31 || r3 >= 21 || m4 >= 5) ? 1 : 0;
    r.n = 0;
    if (r.e == 0)
      for (int x = r1; x < 104160; x += 32)
        if (x % 31 == r2 && x % 21 == r3 && x % 5 == m4) begin
          r.n = x;
          break;
        end
    return r;
  endfunction

  // Monitor: latency from accept to first out_valid, then compare on handshake.
  always @(negedge clk) begin
    if (!reset) begin
      acc_q.delete();
      vld_prev = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (out_valid && !vld_prev) begin
        if (acc_q.size() == 0) chk("latency_no_accept", 1, 0);
        else chk("latency", cyc - acc_q.pop_front(), 4);
      end
      vld_prev = out_valid;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_N", int'(out_N), e.n);
          chk("out_err", int'(out_err), e.e);
        end
      end
    end
  end

  task automatic drive(input int r1, input int r2, input int r3, input int r4);
    bit got = 0;
    @(posedge clk); #1;
    in_mod_1 = 5'(r1); in_mod_2 = 5'(r2); in_mod_3 = 5'(r3); in_mod_4 = 5'(r4);
    in_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(r1, r2, r3, r4));
        got = 1;
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_valid();
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid) return;
    end
    chk("out_valid_timeout", 0, 1);
  endtask

  initial begin
    int held;
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_N", int'(out_N), 0);
    chk("rst_out_err", int'(out_err), 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Directed tuples
    drive(0, 0, 0, 0);
    drive(25, 7, 18, 0);
    drive(31, 30, 20, 4);
    drive(31, 1, 15, 0);
    drive(3, 31, 4, 2);
    drive(0, 0, 0, 5);
    drive(1, 2, 21, 3);

    // Back-pressure: output held, in_ready low, new tuple not taken.
    wait_valid();
    rdy_mode = 1;
    drive(25, 7, 18, 0);
    wait_valid();
    held = int'(out_N);
    in_mod_1 = 5'd31; in_mod_2 = 5'd1; in_mod_3 = 5'd15; in_mod_4 = 5'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", int'(out_valid), 1);
      chk("stall_N", int'(out_N), held);
      chk("stall_in_ready", int'(in_ready), 0);
    end
    rdy_mode = 0;
    drive(31, 1, 15, 0);

    // Reset while in S_A3 aborts without producing output.
    wait_valid();
    @(negedge clk);
    while (!in_ready) @(negedge clk);
    @(posedge clk); #1;
    in_mod_1 = 5'd25; in_mod_2 = 5'd7; in_mod_3 = 5'd18; in_mod_4 = 5'd0;
    in_valid = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", int'(in_ready), 1);
    @(posedge clk); #1 in_valid = 1'b0;   // now in S_A2
    @(posedge clk); #1;                   // now in S_A3
    reset = 1'b0;
    #1;
    chk("abort_in_ready_rst", int'(in_ready), 1);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_out_N", int'(out_N), 0);
    chk("abort_out_err", int'(out_err), 0);
    @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    drive(25, 7, 18, 0);

    // Randomized traffic with random downstream readiness.
    rdy_mode = 2;
    for (int i = 0; i < 2500; i++) begin
      int x, r2, r3, r4;
      x  = $urandom_range(0, 104159);
      r2 = x % 31;
      r3 = x % 21;
      r4 = (x % 5) | (int'($urandom_range(0, 3)) << 3);
      case ($urandom % 16)
        0: r2 = 31;
        1: r3 = $urandom_range(21, 31);
        2: r4 = $urandom_range(5, 7);
        default: ;
      endcase
      drive(x % 32, r2, r3, r4);
    end

    rdy_mode = 0;
    for (int n = 0; n < 1000 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rns2bin_32_31_21_5.md
Name: rns2bin_32_31_21_5

Overview:
- Reverse converter for the moduli set (32, 31, 21, 5). It takes one residue 4-tuple and returns the binary integer X, where 0 <= X < 104160.
- It pairs with the existing binary-to-RNS converter. It sits at the RNS datapath output and drives binary consumers.
- Conversion is multi-cycle Mixed-Radix Conversion (MRC), one mixed-radix digit per cycle. Data moves in and out over valid/ready handshakes.

Parameters:
- DYN_SIZE, 16: output is DYN_SIZE+1 = 17 bits wide.
- MOD_SIZE_1, 5: width of the mod-32 residue.
- MOD_SIZE_2, 5: width of the mod-31 residue.
- MOD_SIZE_3, 5: width of the mod-21 residue.
- MOD_SIZE_4, 3: width of the mod-5 residue.
- MAX_MOD, MOD_SIZE_1: physical width of every residue port.
- These parameters are fixed by the moduli set. They are not a retargeting mechanism.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
- in_mod_1, input, MAX_MOD: residue mod 32.
- in_mod_2, input, MAX_MOD: residue mod 31.
- in_mod_3, input, MAX_MOD: residue mod 21.
- in_mod_4, input, MAX_MOD: residue mod 5. Upper bits beyond MOD_SIZE_4 are ignored.
- in_valid, input, 1: input tuple is valid.
- in_ready, output, 1: block can accept a tuple.
- out_N, output, DYN_SIZE+1: converted binary value.
- out_err, output, 1: the accepted tuple contained an illegal residue.
- out_valid, output, 1: out_N and out_err are valid.
- out_ready, input, 1: downstream accepts the output.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE, in_ready = 1, out_valid = 0, out_N = 0, out_err = 0.
  - All digit and partial-sum registers clear.
  - Asserting reset mid-conversion aborts it. No output is produced for the aborted tuple.
- FSM states: IDLE, S_A2, S_A3, S_A4, DONE. in_ready = 1 only in IDLE.
- IDLE: on in_valid && in_ready, capture r1..r4, set a1 = r1, P = r1, go to S_A2.
  - Also register err = (r1 >= 32) | (r2 >= 31) | (r3 >= 21) | (r4[2:0] >= 5).
  - Note r1 >= 32 can never occur in 5 bits; the term is kept for width-generic code.
- S_A2: a2 = (r2 - (P mod 31)) mod 31. Inverse of 32 mod 31 is 1. Update P = P + 32*a2, go to S_A3.
- S_A3: a3 = ((r3 - (P mod 21)) mod 21) * 17 mod 21. 17 is the inverse of 992 mod 21. Update P = P + 992*a3, go to S_A4.
- S_A4: a4 = ((r4 - (P mod 5)) mod 5) * 3 mod 5. 3 is the inverse of 20832 mod 5.
  - out_N <= P + 20832*a4, or 0 if err.
  - out_err <= err, out_valid <= 1, go to DONE.
- DONE: hold out_N, out_err and out_valid stable while out_ready = 0.
  - On out_ready = 1: out_valid <= 0 and go to IDLE.
- Timing:
  - Latency: out_valid is high in the cycle following the 3rd rising edge after the accepting edge.
  - Throughput: one tuple per 5 cycles. Input and output are never overlapped.
- Arithmetic:
  - All subtractions mod m are done as (a + m - b) with a, b < m. No negative intermediates.
  - Partial sum P is always < 20832 and is held in 15 bits. The final sum is < 104160 and fits in 17 bits.
  - Reductions mod 31/21/5 of P are combinational within the state cycle.
- in_valid while not in IDLE is ignored. The tuple is not captured, and the upstream must hold it.
- out_ready while out_valid = 0 has no effect.

Test Plan:
- Reset, then tuple (0,0,0,0) with out_ready=1 -> out_N=0, out_err=0, out_valid exactly 3 edges after accept, high for 1 cycle.
- Tuple (25,7,18,0) -> out_N=12345. Internal digits a1=25, a2=13, a3=12, a4=0.
- Tuple (31,30,20,4) -> out_N=104159 (maximum). Tuple (31,1,15,0) -> out_N=65535.
- Tuple (3,31,4,2) (illegal r2) -> out_err=1, out_N=0, same latency.
- Hold out_ready=0 for 10 cycles after out_valid -> out_N stable, in_ready=0, a new in_valid is ignored. Releasing out_ready -> IDLE next cycle, and the next tuple is accepted.
- Drop reset to 0 while in S_A3 -> outputs and in_ready return to reset values immediately. After release, the next conversion of (25,7,18,0) yields 12345.
- Sweep of X = 0..104159 through the forward converter into this block -> out_N equals X for every value.
